// File: rtl/rffe_spi_if.sv
// Serial wire and host-side signals of the SSC-framed SPI responder.
// The slave modport is the responder; the master modport is the driving side.
interface rffe_spi_if #(
  parameter int data_depth    = 32,
  parameter int rx_head_depth = 6
);
  logic [7:0]               frame_len;
  logic                     spi_le;
  logic                     spi_sclk;
  logic                     spi_mosi;
  logic                     spi_miso;
  logic [data_depth-1:0]    rx_frame;
  logic                     rx_valid;
  logic                     rd_req;
  logic [rx_head_depth-1:0] rd_head;
  logic [data_depth-1:0]    rd_data;
  logic                     rd_done;
  logic                     frame_err;

  modport slave (
    input  frame_len, spi_le, spi_sclk, spi_mosi, rd_data,
    output spi_miso, rx_frame, rx_valid, rd_req, rd_head, rd_done, frame_err
  );

  modport master (
    output frame_len, spi_le, spi_sclk, spi_mosi, rd_data,
    input  spi_miso, rx_frame, rx_valid, rd_req, rd_head, rd_done, frame_err
  );
endinterface

// File: rtl/rffe_spi_slave.sv
// SSC-framed SPI responder: captures write frames, requests and shifts out read data.
// Serial edges act sync_stages+1 clk after the pin; no backpressure, rd_data must be ready when rd_req pulses.
module rffe_spi_slave #(
  parameter int data_depth    = 32,
  parameter int rx_head_depth = 6,
  parameter int sync_stages   = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  rffe_spi_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SSC_H, SSC_L, HEAD, RD_LOAD, RDATA, WAIT_LE} state_t;

  localparam logic [7:0]            HEAD_LAST = 8'(rx_head_depth - 1);
  localparam logic [data_depth-1:0] ONE       = {{(data_depth-1){1'b0}}, 1'b1};

  logic [sync_stages-1:0]   le_sync, sclk_sync, mosi_sync;
  logic                     le_s, sclk_s, mosi_s, sclk_prev, rise, fall;

  state_t                   state, state_n;
  logic [7:0]               bit_cnt, len_q, idx;
  logic [data_depth-1:0]    shreg, shreg_n, txreg;
  logic [rx_head_depth-2:0] head_sh;
  logic [rx_head_depth-1:0] head_n;
  logic                     is_rd, rd_flag, last, tx_bit;
  logic                     start, shift, wr_done, rd_hit, load, tx, cnt_rd, rd_fin, abort;

  logic                     miso_q, rx_valid_q, rd_req_q, rd_done_q, frame_err_q;
  logic [data_depth-1:0]    rx_frame_q;
  logic [rx_head_depth-1:0] rd_head_q;

  // le idles high so the synchronizer must not fake a frame start out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      le_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      le_sync   <= {le_sync[sync_stages-2:0], bus.spi_le};
      sclk_sync <= {sclk_sync[sync_stages-2:0], bus.spi_sclk};
      mosi_sync <= {mosi_sync[sync_stages-2:0], bus.spi_mosi};
      sclk_prev <= sclk_s;
    end
  end

  assign le_s    = le_sync[sync_stages-1];
  assign sclk_s  = sclk_sync[sync_stages-1];
  assign mosi_s  = mosi_sync[sync_stages-1];
  assign rise    = sclk_s & ~sclk_prev;
  assign fall    = ~sclk_s & sclk_prev;

  assign idx     = len_q - 8'd1 - bit_cnt;
  assign last    = (bit_cnt + 8'd1) == len_q;
  assign rd_flag = (bit_cnt == 8'd0) ? mosi_s : is_rd;
  assign shreg_n = mosi_s ? (shreg | (ONE << idx)) : shreg;
  assign head_n  = {head_sh, mosi_s};
  assign tx_bit  = |(txreg & (ONE << idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    shift   = 1'b0;
    wr_done = 1'b0;
    rd_hit  = 1'b0;
    load    = 1'b0;
    tx      = 1'b0;
    cnt_rd  = 1'b0;
    rd_fin  = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE:    if (!le_s) state_n = SSC_H;
      SSC_H: begin
        if (le_s)                  state_n = IDLE;
        else if (mosi_s && !sclk_s) state_n = SSC_L;
      end
      SSC_L: begin
        if (le_s) state_n = IDLE;
        else if (!mosi_s) begin
          state_n = HEAD;
          start   = 1'b1;
        end
      end
      HEAD: begin
        shift = fall;
        // a final bit landing with le rising still completes the frame
        if (fall && rd_flag && bit_cnt == HEAD_LAST) begin
          rd_hit  = 1'b1;
          state_n = RD_LOAD;
        end else if (fall && !rd_flag && last) begin
          wr_done = 1'b1;
          state_n = WAIT_LE;
        end else if (le_s) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      RD_LOAD: begin
        if (le_s) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else begin
          load    = 1'b1;
          state_n = RDATA;
        end
      end
      RDATA: begin
        tx     = rise;
        cnt_rd = fall;
        if (fall && last) begin
          rd_fin  = 1'b1;
          state_n = WAIT_LE;
        end else if (le_s) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      WAIT_LE: if (le_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      len_q       <= '0;
      shreg       <= '0;
      txreg       <= '0;
      head_sh     <= '0;
      is_rd       <= 1'b0;
      miso_q      <= 1'b0;
      rx_frame_q  <= '0;
      rd_head_q   <= '0;
      rx_valid_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= wr_done;
      rd_req_q    <= rd_hit;
      rd_done_q   <= rd_fin;
      frame_err_q <= abort;
      if (start) begin
        bit_cnt <= '0;
        len_q   <= bus.frame_len;
        shreg   <= '0;
      end else if (shift || cnt_rd) begin
        bit_cnt <= bit_cnt + 8'd1;
      end
      if (shift) begin
        shreg   <= shreg_n;
        head_sh <= head_n[rx_head_depth-2:0];
        if (bit_cnt == 8'd0) is_rd <= mosi_s;
      end
      if (wr_done) rx_frame_q <= shreg_n;
      if (rd_hit)  rd_head_q  <= head_n;
      if (load)    txreg      <= bus.rd_data;
      if (abort || rd_fin) miso_q <= 1'b0;
      else if (tx)         miso_q <= tx_bit;
    end
  end

  assign bus.spi_miso  = miso_q;
  assign bus.rx_frame  = rx_frame_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.rd_head   = rd_head_q;
  assign bus.rd_done   = rd_done_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_rffe_spi_slave.sv
// Bench for rffe_spi_slave: a bit-level SSC master, a table of directed frames and random frames.
`timescale 1ns/1ps
module tb_rffe_spi_slave;
  localparam int DD = 32;
  localparam int HD = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rffe_spi_if #(.data_depth(DD), .rx_head_depth(HD)) bus ();

  rffe_spi_slave #(.data_depth(DD), .rx_head_depth(HD), .sync_stages(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit          rd;
    int          len;
    logic [31:0] data;
    logic [31:0] rdd;
    int          hp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int n_rxv = 0, n_req = 0, n_done = 0, n_err = 0, n_miso = 0, n_multi = 0;

  always @(negedge clk) begin
    n_rxv  += int'(bus.rx_valid);
    n_req  += int'(bus.rd_req);
    n_done += int'(bus.rd_done);
    n_err  += int'(bus.frame_err);
    n_miso += int'(bus.spi_miso);
    if (int'(bus.rx_valid) + int'(bus.rd_req) + int'(bus.rd_done) + int'(bus.frame_err) > 1)
      n_multi++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mask(input int n);
    if (n >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << n) - 32'd1;
  endfunction

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master side: le fall, SSC, then L bits MSB first; miso sampled at each sclk fall.
  task automatic send_frame(input logic [31:0] data, input int len, input int hp, input bit rd,
                            input int abort_at, input bit fast_end, output logic [31:0] capt);
    capt = '0;
    bus.spi_le   = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    wclk(hp);
    bus.spi_mosi = 1'b1;
    wclk(hp);
    bus.spi_mosi = 1'b0;
    wclk(hp);
    for (int i = len - 1; i >= 0; i--) begin
      if (len - 1 - i == abort_at) break;
      bus.spi_sclk = 1'b1;
      bus.spi_mosi = (rd && i < len - HD) ? 1'b0 : data[i];
      wclk(hp);
      bus.spi_sclk = 1'b0;
      capt[i] = bus.spi_miso;
      if (i == 0 && fast_end) bus.spi_le = 1'b1;
      wclk(hp);
    end
    bus.spi_mosi = 1'b0;
    wclk(hp);
    bus.spi_le = 1'b1;
    wclk(2 * hp);
  endtask

  task automatic run_vec(input vec_t v);
    int b_rxv, b_req, b_done, b_err, b_miso;
    logic [31:0] capt;
    bus.frame_len = 8'(v.len);
    bus.rd_data   = v.rdd;
    b_rxv = n_rxv; b_req = n_req; b_done = n_done; b_err = n_err; b_miso = n_miso;
    send_frame(v.data, v.len, v.hp, v.rd, -1, 1'b0, capt);
    chk("frame_err_cnt", 32'(n_err - b_err), 32'd0);
    if (v.rd) begin
      chk("rd_req_cnt", 32'(n_req - b_req), 32'd1);
      chk("rd_done_cnt", 32'(n_done - b_done), 32'd1);
      chk("rx_valid_cnt_rd", 32'(n_rxv - b_rxv), 32'd0);
      chk("rd_head", 32'(bus.rd_head), (v.data >> (v.len - HD)) & mask(HD));
      chk("miso_data", capt, v.rdd & mask(v.len - HD));
    end else begin
      chk("rx_valid_cnt", 32'(n_rxv - b_rxv), 32'd1);
      chk("rd_req_cnt_wr", 32'(n_req - b_req), 32'd0);
      chk("rd_done_cnt_wr", 32'(n_done - b_done), 32'd0);
      chk("miso_quiet_wr", 32'(n_miso - b_miso), 32'd0);
      chk("rx_frame", bus.rx_frame, v.data & mask(v.len));
    end
  endtask

  initial begin
    vec_t vt[5];
    vec_t rv;
    logic [31:0] capt;
    int b_rxv, b_req, b_done, b_err;

    vt[0] = '{rd: 1'b0, len: 32, data: 32'h2ABC_DEF0, rdd: 32'h0,         hp: 5};
    vt[1] = '{rd: 1'b1, len: 32, data: 32'h9400_0000, rdd: 32'h0155_AA33, hp: 5};
    vt[2] = '{rd: 1'b0, len: 16, data: 32'h0000_7F01, rdd: 32'h0,         hp: 4};
    vt[3] = '{rd: 1'b1, len: 16, data: 32'h0000_CC00, rdd: 32'hDEAD_BEEF, hp: 6};
    vt[4] = '{rd: 1'b0, len: 7,  data: 32'h0000_0035, rdd: 32'h0,         hp: 4};

    bus.frame_len = 8'd32;
    bus.spi_le    = 1'b1;
    bus.spi_sclk  = 1'b0;
    bus.spi_mosi  = 1'b0;
    bus.rd_data   = '0;
    #2 rst_n = 1'b0;
    wclk(3);
    rst_n = 1'b1;
    wclk(3);

    chk("reset_rx_frame", bus.rx_frame, 32'h0);
    chk("reset_rd_head", 32'(bus.rd_head), 32'h0);
    chk("reset_miso", 32'(bus.spi_miso), 32'h0);
    chk("reset_pulses", 32'(n_rxv + n_req + n_done + n_err), 32'h0);

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // le pulled high after 10 bits of a write
    bus.frame_len = 8'd32;
    b_rxv = n_rxv; b_err = n_err;
    send_frame(32'h1357_9BDF, 32, 5, 1'b0, 10, 1'b0, capt);
    chk("abort_frame_err", 32'(n_err - b_err), 32'd1);
    chk("abort_no_rx_valid", 32'(n_rxv - b_rxv), 32'd0);
    run_vec('{rd: 1'b0, len: 32, data: 32'h0F0F_A5A5, rdd: 32'h0, hp: 5});

    // no SSC: sclk toggles with mosi low, then le returns high
    b_rxv = n_rxv; b_req = n_req; b_done = n_done; b_err = n_err;
    bus.spi_le   = 1'b0;
    bus.spi_mosi = 1'b0;
    wclk(5);
    for (int i = 0; i < 8; i++) begin
      bus.spi_sclk = 1'b1;
      wclk(5);
      bus.spi_sclk = 1'b0;
      wclk(5);
    end
    bus.spi_le = 1'b1;
    wclk(10);
    chk("nossc_pulses", 32'(n_rxv - b_rxv + n_req - b_req + n_done - b_done + n_err - b_err), 32'd0);
    chk("nossc_miso", 32'(bus.spi_miso), 32'd0);
    run_vec('{rd: 1'b1, len: 20, data: 32'h000A_C000, rdd: 32'hFFFF_1234, hp: 5});

    // le rises on the same edge as the final sclk fall
    bus.frame_len = 8'd20;
    b_rxv = n_rxv; b_err = n_err;
    send_frame(32'h0006_5A3C, 20, 5, 1'b0, -1, 1'b1, capt);
    chk("same_edge_rx_valid", 32'(n_rxv - b_rxv), 32'd1);
    chk("same_edge_no_err", 32'(n_err - b_err), 32'd0);
    chk("same_edge_rx_frame", bus.rx_frame, 32'h0006_5A3C);

    // async reset in the middle of a read phase
    bus.frame_len = 8'd32;
    bus.rd_data   = 32'h03FF_FFFF;
    b_rxv = n_rxv; b_done = n_done; b_err = n_err;
    fork
      send_frame(32'hA800_0000, 32, 5, 1'b1, -1, 1'b0, capt);
      begin
        wclk(150);
        rst_n = 1'b0;
        #1;
        chk("rst_rx_frame", bus.rx_frame, 32'h0);
        chk("rst_rd_head", 32'(bus.rd_head), 32'h0);
        chk("rst_miso", 32'(bus.spi_miso), 32'h0);
        chk("rst_pulses", 32'(int'(bus.rx_valid) + int'(bus.rd_req) + int'(bus.rd_done) + int'(bus.frame_err)), 32'h0);
        wclk(3);
        rst_n = 1'b1;
      end
    join
    chk("rst_no_rd_done", 32'(n_done - b_done), 32'd0);
    chk("rst_no_frame_err", 32'(n_err - b_err), 32'd0);
    chk("rst_no_rx_valid", 32'(n_rxv - b_rxv), 32'd0);
    run_vec('{rd: 1'b0, len: 32, data: 32'h1234_5678, rdd: 32'h0, hp: 5});

    // random frames against the length/flag model
    for (int i = 0; i < 12; i++) begin
      rv.len  = int'($urandom_range(32, 7));
      rv.rd   = 1'($urandom_range(1, 0));
      rv.hp   = int'($urandom_range(7, 4));
      rv.rdd  = $urandom;
      rv.data = $urandom & mask(rv.len);
      if (rv.rd) rv.data = rv.data | (32'd1 << (rv.len - 1));
      else       rv.data = rv.data & ~(32'd1 << (rv.len - 1));
      run_vec(rv);
    end

    chk("pulse_overlap", 32'(n_multi), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
